// File: rtl/spi_flash_reader.sv
// spi_flash_reader: single-bit SPI NOR READ (0x03) initiator that
// streams the received bytes out over a valid/ready interface.
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic             flash_csb,
    output logic             flash_clk,
    output logic             flash_io0,
    input  logic             flash_io1
);

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT_OUT,
        SHIFT_IN,
        WAIT_RDY,
        HOLD,
        FINISH
    } state_t;

    state_t           state;
    logic [7:0]       div_cnt;
    logic [5:0]       bit_cnt;
    logic [30:0]      shreg;
    logic [6:0]       rx;
    logic [LEN_W-1:0] count;
    logic             div_tick;
    logic             handshake;

    assign div_tick  = (div_cnt == DIV_LAST);
    assign handshake = rd_valid && rd_ready;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx        <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= 8'h00;
            rd_valid  <= 1'b0;
            flash_csb <= 1'b1;
            flash_clk <= 1'b0;
            flash_io0 <= 1'b0;
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            flash_csb <= 1'b1;
            flash_clk <= 1'b0;
            flash_io0 <= 1'b0;
        end else begin
            done <= 1'b0;
            // a byte may be consumed in SHIFT_IN already, before SCK falls
            if (handshake) begin
                rd_valid <= 1'b0;
                count    <= count - LEN_W'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            shreg     <= {CMD_READ[6:0], addr};
                            count     <= len;
                            flash_csb <= 1'b0;
                            flash_io0 <= CMD_READ[7];
                            busy      <= 1'b1;
                            div_cnt   <= '0;
                            bit_cnt   <= '0;
                            state     <= SETUP;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                SETUP: begin
                    if (div_tick) begin
                        div_cnt <= '0;
                        state   <= SHIFT_OUT;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                SHIFT_OUT: begin
                    if (!div_tick) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt   <= '0;
                        flash_clk <= ~flash_clk;
                        if (flash_clk) begin
                            shreg <= {shreg[29:0], 1'b0};
                            if (bit_cnt == 6'd31) begin
                                flash_io0 <= 1'b0;
                                bit_cnt   <= '0;
                                state     <= SHIFT_IN;
                            end else begin
                                flash_io0 <= shreg[30];
                                bit_cnt   <= bit_cnt + 6'd1;
                            end
                        end
                    end
                end
                SHIFT_IN: begin
                    if (!div_tick) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt   <= '0;
                        flash_clk <= ~flash_clk;
                        if (!flash_clk) begin
                            rx      <= {rx[5:0], flash_io1};
                            bit_cnt <= bit_cnt + 6'd1;
                            if (bit_cnt == 6'd7) begin
                                rd_data  <= {rx, flash_io1};
                                rd_valid <= 1'b1;
                            end
                        end else if (bit_cnt == 6'd8) begin
                            bit_cnt <= '0;
                            state   <= WAIT_RDY;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (!rd_valid) begin
                        div_cnt <= '0;
                        state   <= (count != '0) ? SHIFT_IN : HOLD;
                    end
                end
                HOLD: begin
                    if (div_tick) begin
                        div_cnt   <= '0;
                        flash_csb <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FINISH;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: three divider settings against a
// behavioural SPI flash and a byte-queue reference of the memory.
module tb_spi_flash_reader;

    localparam int N = 3;

    function automatic int div_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    endfunction

    logic          clk = 1'b0;
    logic          nrst;
    logic [N-1:0]  start;
    logic [23:0]   addr;
    logic [15:0]   len;
    logic          abort;
    logic          rd_ready;
    logic [N-1:0]  busy, done, rv, csb, sck, mosi, miso;
    logic [7:0]    rdd [N];

    logic [7:0]    mem [4096];
    int            fb [N];
    int            t0 [N];
    int            t1 [N];
    logic [31:0]   cmd_w [N];
    logic [N-1:0]  sck_q;
    int            cyc;
    int            idx;
    logic [23:0]   ba;
    logic [7:0]    byt;
    logic [7:0]    got_q [$];
    int            done_cnt;
    int            n_cmp = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        spi_flash_reader #(
            .CLK_DIV(div_of(g)),
            .LEN_W  (16)
        ) dut (
            .clk      (clk),
            .nrst     (nrst),
            .start    (start[g]),
            .addr     (addr),
            .len      (len),
            .abort    (abort),
            .busy     (busy[g]),
            .done     (done[g]),
            .rd_data  (rdd[g]),
            .rd_valid (rv[g]),
            .rd_ready (rd_ready),
            .flash_csb(csb[g]),
            .flash_clk(sck[g]),
            .flash_io0(mosi[g]),
            .flash_io1(miso[g])
        );
    end

    // flash responder (mode 0) plus stream/done monitor, all at negedge
    always @(negedge clk) begin
        cyc++;
        for (int g = 0; g < N; g++) begin
            if (csb[g]) begin
                fb[g]   = 0;
                miso[g] = 1'b0;
            end else if (sck[g] && !sck_q[g]) begin
                if (fb[g] == 0) t0[g] = cyc;
                if (fb[g] == 1) t1[g] = cyc;
                if (fb[g] < 32) cmd_w[g] = {cmd_w[g][30:0], mosi[g]};
                fb[g]++;
            end else if (!sck[g] && sck_q[g] && fb[g] >= 32) begin
                idx     = fb[g] - 32;
                ba      = cmd_w[g][23:0] + 24'(idx / 8);
                byt     = mem[ba[11:0]];
                miso[g] = byt[7 - (idx % 8)];
            end
            sck_q[g] = sck[g];
            if (rv[g] && rd_ready && !abort && nrst) got_q.push_back(rdd[g]);
            if (done[g]) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int s, input logic [23:0] a,
                           input int l, input int stall);
        logic [7:0] exp_q [$];
        logic [7:0] held;
        bit         bad;
        int         waited;
        exp_q = {};
        for (int i = 0; i < l; i++) exp_q.push_back(mem[12'(a + 24'(i))]);
        got_q    = {};
        done_cnt = 0;
        cmd_w[s] = '0;
        t0[s]    = 0;
        t1[s]    = 0;
        addr     = a;
        len      = 16'(l);
        rd_ready = (stall == 0);
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        check("busy_after_start", busy[s], 1);
        check("csb_after_start", csb[s], 0);
        waited = 0;
        while (done_cnt == 0 && waited < 20000) begin
            if (stall != 0 && rv[s] && !rd_ready) begin
                held = rdd[s];
                bad  = 1'b0;
                for (int k = 0; k < stall; k++) begin
                    tick();
                    waited++;
                    if (k > div_of(s) && sck[s]) bad = 1'b1;
                    if (csb[s] || !rv[s] || rdd[s] !== held) bad = 1'b1;
                end
                check("stall_hold", 32'(bad), 0);
                rd_ready = 1'b1;
                tick();
                waited++;
                rd_ready = 1'b0;
            end else begin
                tick();
                waited++;
            end
        end
        check("done_seen", done_cnt, 1);
        check("byte_count", got_q.size(), l);
        for (int i = 0; i < l; i++)
            check("rd_byte",
                  (i < got_q.size()) ? 32'(got_q[i]) : 32'hffff_ffff,
                  32'(exp_q[i]));
        check("mosi_cmd_addr", cmd_w[s], {8'h03, a});
        check("sck_period", t1[s] - t0[s], 2 * div_of(s));
        tick();
        check("csb_idle", csb[s], 1);
        check("busy_idle", busy[s], 0);
        check("single_done", done_cnt, 1);
    endtask

    task automatic zero_len(input int s);
        done_cnt = 0;
        addr     = 24'($urandom);
        len      = 16'd0;
        start[s] = 1'b1;
        tick();
        start[s] = 1'b0;
        check("zl_done", done[s], 1);
        check("zl_busy", busy[s], 0);
        check("zl_csb", csb[s], 1);
        tick();
        check("zl_done_off", done[s], 0);
        check("zl_busy2", busy[s], 0);
        check("zl_csb2", csb[s], 1);
        repeat (5) tick();
        check("zl_done_count", done_cnt, 1);
    endtask

    task automatic cancel_test(input bit use_reset);
        int waited;
        got_q    = {};
        done_cnt = 0;
        addr     = 24'h000100;
        len      = 16'd4;
        rd_ready = 1'b1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        waited = 0;
        while (got_q.size() < 1 && waited < 5000) begin
            tick();
            waited++;
        end
        repeat (20) tick();
        check("inflight_csb", csb[0], 0);
        if (use_reset) nrst = 1'b0;
        else abort = 1'b1;
        tick();
        nrst  = 1'b1;
        abort = 1'b0;
        check("cancel_csb", csb[0], 1);
        check("cancel_valid", rv[0], 0);
        check("cancel_busy", busy[0], 0);
        check("cancel_sck", sck[0], 0);
        repeat (20) tick();
        check("cancel_no_done", done_cnt, 0);
        check("cancel_bytes", got_q.size(), 1);
        check("cancel_first", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hffff_ffff,
              32'hde);
        do_read(0, 24'h000102, 2, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int l;
        int st;
        logic [23:0] a;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[12'h100] = 8'hde;
        mem[12'h101] = 8'had;
        mem[12'h102] = 8'hbe;
        mem[12'h103] = 8'hef;
        for (int g = 0; g < N; g++) begin
            fb[g]    = 0;
            t0[g]    = 0;
            t1[g]    = 0;
            cmd_w[g] = '0;
        end
        sck_q    = '0;
        miso     = '0;
        cyc      = 0;
        done_cnt = 0;
        nrst     = 1'b0;
        start    = '0;
        addr     = '0;
        len      = '0;
        abort    = 1'b0;
        rd_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            start = N'($urandom);
            len   = 16'd4;
            tick();
            check("rst_ctrl", {csb, sck, mosi, busy, done, rv},
                  {3'b111, 15'b0});
            check("rst_data", {rdd[0], rdd[1], rdd[2]}, 0);
        end
        start = '0;
        nrst  = 1'b1;
        tick();

        do_read(0, 24'h000100, 4, 0);
        do_read(0, 24'h000100, 4, 50);
        zero_len(0);
        zero_len(2);
        cancel_test(1'b0);
        cancel_test(1'b1);
        do_read(1, 24'h000100, 4, 0);
        do_read(2, 24'h000100, 4, 0);

        for (int r = 0; r < 8; r++) begin
            s  = $urandom_range(0, N - 1);
            a  = 24'($urandom);
            l  = $urandom_range(1, 5);
            st = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
            do_read(s, a, l, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_flash_reader.md
Name: spi_flash_reader

Overview:
- SPI initiator that issues standard single-bit READ (0x03) transactions to an external SPI NOR flash on flash_csb/flash_clk/flash_io0/flash_io1.
- Returns bytes on a valid/ready stream.
- Lets user-project logic fetch tables or program data from the same flash device the management SoC boots from.
- Talks to the existing spiflash simulation model as responder.

Parameters:
- CLK_DIV, 2, flash_clk half-period in clk cycles; SCK frequency = f_clk/(2*CLK_DIV); legal values 1..255.
- LEN_W, 16, width of the byte-count input.

Ports:
- clk  input  1  system clock, rising-edge.
- nrst  input  1  synchronous active-low reset.
- start  input  1  request a read; sampled only in IDLE.
- addr  input  24  flash byte address; captured on accepted start.
- len  input  LEN_W  number of bytes to read; captured on accepted start.
- abort  input  1  synchronous cancel of the current transaction.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse on normal completion.
- rd_data  output  8  received byte, MSB first on the wire.
- rd_valid  output  1  rd_data holds an unconsumed byte.
- rd_ready  input  1  consumer accepts the byte when rd_valid&rd_ready.
- flash_csb  output  1  chip select, active low.
- flash_clk  output  1  SPI clock, mode 0 (idles low).
- flash_io0  output  1  MOSI.
- flash_io1  input  1  MISO.

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is synchronous and active-low.
- Reset values: flash_csb=1, flash_clk=0, flash_io0=0, busy=0, done=0, rd_valid=0, rd_data=8'h00. State=IDLE, all counters 0.
- Reset mid-transaction: on the first clk edge with nrst=0, all of the above apply. csb deasserts immediately and no done pulse is produced.
- States: IDLE, SETUP, SHIFT_OUT, SHIFT_IN, WAIT_RDY, HOLD, FINISH.
- IDLE, start=1, len!=0:
  - Capture addr and len.
  - Load the 32-bit shift register with {8'h03, addr}.
  - Next cycle: flash_csb=0, busy=1, flash_io0 = bit 31, go to SETUP.
- IDLE, start=1, len==0: no flash activity, csb stays 1. done pulses on the following cycle; busy stays 0.
- SETUP: hold CLK_DIV cycles with SCK low, then go to SHIFT_OUT.
- SCK generation: an internal divider toggles flash_clk every CLK_DIV cycles.
  - Rising toggle: sample flash_io1.
  - Falling toggle: shift out the next MOSI bit.
  - The first MOSI bit is valid before the first rising edge.
- SHIFT_OUT: 32 SCK periods. After the 32nd falling edge, flash_io0=0 and go to SHIFT_IN.
- SHIFT_IN:
  - 8 SCK periods per byte, bits shifted in MSB first.
  - On the 8th rising-edge sample, load rd_data and set rd_valid=1.
  - flash_clk returns low at its normal falling toggle, then go to WAIT_RDY.
- WAIT_RDY:
  - SCK held low, csb held low, rd_data stable.
  - On rd_valid&rd_ready: rd_valid=0 next cycle and the remaining count is decremented.
  - If count is nonzero, resume SHIFT_IN with no extra setup; otherwise go to HOLD.
- Same-cycle handshake: if rd_ready is already high when rd_valid rises, the byte is consumed the cycle rd_valid is observed high. Minimum one cycle of rd_valid.
- HOLD: CLK_DIV cycles with csb low and SCK low, then csb=1 and go to FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- Back-to-back: a start in the cycle after done is accepted, giving at least 1 cycle of csb high. The flash model requires no more.
- start while busy: ignored, no queuing.
- abort=1 in any non-IDLE state:
  - Next cycle: csb=1, flash_clk=0, flash_io0=0, rd_valid=0, busy=0, state=IDLE.
  - No done pulse.
  - abort has priority over start and over rd_ready in the same cycle.
- Address wrap: addr+len beyond 24'hFFFFFF is not checked; the flash wraps internally.
- len counter: LEN_W bits, maximum 2^LEN_W-1 bytes per transaction.
- Nominal latency, CLK_DIV=2, rd_ready tied high: accepted start to first rd_valid = 1+2+32*4+8*4 = 163 cycles, ±1 for the registered output. Each further byte adds 32 cycles plus 1 handshake cycle.

Test Plan:
- Reset and idle: hold nrst=0 for 5 cycles while toggling start. All outputs must stay at reset values with csb=1 throughout.
- Command and address check:
  - Stimulus: start, addr=24'h000100, len=4, flash model preloaded with DE AD BE EF at 0x100.
  - MOSI sampled on SCK rising edges must read 0x03, 0x00, 0x01, 0x00.
  - Stream must deliver DE, AD, BE, EF, then one done pulse; csb returns high.
- Backpressure: same read with rd_ready held low for 50 cycles after each rd_valid.
  - During each stall, flash_clk stays 0, csb stays 0 and rd_data is stable.
  - Final byte sequence is unchanged.
- Zero length: start with len=0. No csb activity; done pulses exactly 1 cycle after start; busy never rises.
- Abort and reset mid-operation:
  - abort during the 2nd data byte: csb=1 next cycle, rd_valid=0, no done pulse.
  - A following start with addr=24'h000102, len=2 returns BE, EF.
  - Repeat with nrst pulsed low instead of abort: same outcome.
- Divider sweep: CLK_DIV=1 and CLK_DIV=4 with the 4-byte read. Data correct, and the SCK period measures 2 and 8 clk cycles respectively.
